mac_feeder: RTL and testbench

MAC_FEEDER -- requirements
Module: mac_feeder

---
 rtl/mac_pkg.sv | 24 ++
 rtl/mac_feeder_if.sv | 35 +++
 rtl/mac_feeder.sv | 133 +++++++++++++
 tb/tb_mac_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand feeder: FSM encoding, default widths
// and the drain length that covers the feeder register plus the MAC pipeline.
package mac_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int LEN_W_DEF    = 8;
  localparam int DRAIN_CYCLES = 4;

  // The drain counter is loaded with N-1 and the closing edge is taken at zero.
  localparam logic [1:0] DRAIN_RELOAD = 2'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  function automatic logic state_is_busy(input state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// Job, operand-stream, MAC and result signals of the feeder grouped in one bundle.
// The slave modport is the feeder; the master modport is its environment.
interface mac_feeder_if
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              mac_rst;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic [DATA_W-1:0] mac_acc;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;

  modport master (
    output start, len, op_valid, op_a, op_b, mac_acc, res_ready,
    input  busy, op_ready, mac_rst, mac_a, mac_b, res_valid, res_data
  );

  modport slave (
    input  start, len, op_valid, op_a, op_b, mac_acc, res_ready,
    output busy, op_ready, mac_rst, mac_a, mac_b, res_valid, res_data
  );

endinterface

// File: rtl/mac_feeder.sv
// Feeds a job of operand pairs into an external pipelined MAC, waits for the
// pipeline to drain and returns the accumulated sum over a valid/ready handshake.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input logic         clk,
  input logic         rst,
  mac_feeder_if.slave bus
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        drain_q, drain_d;
  logic [DATA_W-1:0] mac_a_q, mac_a_d;
  logic [DATA_W-1:0] mac_b_q, mac_b_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_valid_q, res_valid_d;
  logic              clear_q, clear_d;
  logic              busy_q, busy_d;
  logic              hs_s;

  assign hs_s = (state_q == ST_STREAM) && bus.op_valid;

  // Next-state, counters and registered datapath values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;

    // Non-handshake cycles feed zeros so the accumulator is left unchanged.
    if (hs_s) begin
      mac_a_d = bus.op_a;
      mac_b_d = bus.op_b;
    end else begin
      mac_a_d = '0;
      mac_b_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_d   = bus.len;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_q != '0) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_RELOAD;
        end
      end
      ST_STREAM: begin
        if (hs_s) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_RELOAD;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'd0) begin
          res_data_d  = bus.mac_acc;
          res_valid_d = 1'b1;
          state_d     = ST_RESULT;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      ST_RESULT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    clear_d = (state_d == ST_CLEAR);
    busy_d  = state_is_busy(state_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      drain_q     <= 2'd0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      clear_q     <= clear_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.op_ready  = (state_q == ST_STREAM);
  assign bus.mac_rst   = clear_q | rst;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder with a 3-stage MAC model beside it; job
// results are predicted as product sums mod 2^16 and latencies as edge counts.
module tb_mac_feeder;
  import mac_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic op_ready_seen;
  logic res_valid_seen;
  logic [15:0] ja[$];
  logic [15:0] jb[$];

  mac_feeder_if #(.DATA_W(16), .LEN_W(8)) bus ();

  mac_feeder #(.DATA_W(16), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream MAC: multiply, one delay stage, accumulate.
  logic [15:0] p1, p2, acc;
  always @(posedge clk) begin
    if (bus.mac_rst) begin
      p1 <= 16'd0; p2 <= 16'd0; acc <= 16'd0;
    end else begin
      p1  <= bus.mac_a * bus.mac_b;
      p2  <= p1;
      acc <= acc + p2;
    end
  end
  assign bus.mac_acc = acc;

  always @(negedge clk) begin
    if (bus.op_ready)  op_ready_seen  = 1'b1;
    if (bus.res_valid) res_valid_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the job held in ja/jb and checks handshakes, latency, result and release.
  task automatic run_job(input int gap_lo, input int gap_hi, input int hold, input string nm);
    int n;
    int k;
    int w;
    int gaps;
    longint s;
    logic [15:0] exp_sum;
    logic [15:0] held;
    n = ja.size();
    s = 0;
    for (int i = 0; i < n; i++) s = s + longint'(ja[i]) * longint'(jb[i]);
    exp_sum = 16'(s);
    op_ready_seen = 1'b0;
    bus.len = 8'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.op_valid = 1'b0;
      gaps = $urandom_range(gap_hi, gap_lo);
      for (int g = 0; g < gaps; g++) begin
        tick();
        total++;
        if (bus.mac_a !== 16'd0 || bus.mac_b !== 16'd0) begin
          bad++;
          $display("FAIL %s gap_zero: mac_a=%0d mac_b=%0d exp=0", nm, bus.mac_a, bus.mac_b);
        end
      end
      bus.op_valid = 1'b1;
      bus.op_a = ja[i];
      bus.op_b = jb[i];
      w = 0;
      while (!bus.op_ready && w < 20) begin tick(); w++; end
      if (w >= 20) begin
        total++; bad++;
        $display("FAIL %s op_ready_timeout: waited=%0d", nm, w);
      end
      tick();
      total++;
      if (bus.mac_a !== ja[i] || bus.mac_b !== jb[i]) begin
        bad++;
        $display("FAIL %s mac_operands: got=%0d,%0d exp=%0d,%0d", nm, bus.mac_a, bus.mac_b, ja[i], jb[i]);
      end
    end
    bus.op_valid = 1'b0;
    k = 0;
    while (!bus.res_valid && k < 60) begin tick(); k++; end
    total++;
    if (k !== ((n == 0) ? 5 : 4)) begin
      bad++;
      $display("FAIL %s latency: got=%0d exp=%0d", nm, k, (n == 0) ? 5 : 4);
    end
    total++;
    if (bus.res_data !== exp_sum) begin
      bad++;
      $display("FAIL %s res_data: got=%0d exp=%0d", nm, bus.res_data, exp_sum);
    end
    if (n == 0) begin
      total++;
      if (op_ready_seen !== 1'b0) begin
        bad++;
        $display("FAIL %s op_ready_pulse: got=%0b exp=0", nm, op_ready_seen);
      end
    end
    held = bus.res_data;
    for (int h = 0; h < hold; h++) begin
      bus.start = (h == 2) ? 1'b1 : 1'b0;
      tick();
      total++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== held) begin
        bad++;
        $display("FAIL %s hold: valid=%0b data=%0d exp_data=%0d", nm, bus.res_valid, bus.res_data, held);
      end
    end
    bus.start = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s release: busy=%0b valid=%0b exp=0,0", nm, bus.busy, bus.res_valid);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s no_requeue: busy=%0b exp=0", nm, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.len = 8'd3;
    tick();
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0 || bus.mac_rst !== 1'b1 ||
        bus.res_valid !== 1'b0 || bus.res_data !== 16'd0 ||
        bus.mac_a !== 16'd0 || bus.mac_b !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%0b rdy=%0b mac_rst=%0b rv=%0b rd=%0d a=%0d b=%0d",
               bus.busy, bus.op_ready, bus.mac_rst, bus.res_valid, bus.res_data, bus.mac_a, bus.mac_b);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.mac_rst !== 1'b0) begin
      bad++;
      $display("FAIL reset_wins: busy=%0b mac_rst=%0b exp=0,0", bus.busy, bus.mac_rst);
    end
  endtask

  task automatic test_back_to_back();
    ja = '{16'd1, 16'd3, 16'd5};
    jb = '{16'd2, 16'd4, 16'd6};
    run_job(0, 0, 0, "b2b");
  endtask

  task automatic test_len_zero();
    ja.delete();
    jb.delete();
    run_job(0, 0, 0, "len0");
  endtask

  task automatic test_gaps();
    ja = '{16'd1, 16'd3, 16'd5};
    jb = '{16'd2, 16'd4, 16'd6};
    run_job(2, 2, 0, "gaps");
  endtask

  task automatic test_wrap();
    ja = '{16'd300};
    jb = '{16'd300};
    run_job(0, 0, 0, "wrap");
  endtask

  task automatic test_result_hold();
    ja = '{16'd9, 16'd10};
    jb = '{16'd11, 16'd12};
    run_job(0, 1, 5, "hold");
  endtask

  task automatic test_reset_midjob();
    bus.len = 8'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int w;
      bus.op_valid = 1'b1;
      bus.op_a = 16'(100 + i);
      bus.op_b = 16'(50 + i);
      w = 0;
      while (!bus.op_ready && w < 20) begin tick(); w++; end
      tick();
    end
    bus.op_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (bus.mac_rst !== 1'b1) begin
      bad++;
      $display("FAIL midjob_mac_rst: got=%0b exp=1", bus.mac_rst);
    end
    tick();
    rst = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0 || bus.mac_a !== 16'd0 || bus.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL midjob_reset: busy=%0b rdy=%0b a=%0d rv=%0b exp=0", bus.busy, bus.op_ready, bus.mac_a, bus.res_valid);
    end
    res_valid_seen = 1'b0;
    repeat (8) tick();
    total++;
    if (res_valid_seen !== 1'b0) begin
      bad++;
      $display("FAIL midjob_stale: res_valid_seen=%0b exp=0", res_valid_seen);
    end
    ja = '{16'd7, 16'd2};
    jb = '{16'd8, 16'd2};
    run_job(0, 0, 0, "after_rst");
  endtask

  task automatic test_random();
    for (int j = 0; j < 12; j++) begin
      int n;
      n = $urandom_range(6, 0);
      ja.delete();
      jb.delete();
      for (int i = 0; i < n; i++) begin
        ja.push_back(16'($urandom));
        jb.push_back(16'($urandom));
      end
      run_job(0, 2, 0, "random");
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.len = 8'd0;
    bus.op_valid = 1'b0;
    bus.op_a = 16'd0;
    bus.op_b = 16'd0;
    bus.res_ready = 1'b0;
    op_ready_seen = 1'b0;
    res_valid_seen = 1'b0;
    test_reset();
    test_back_to_back();
    test_len_zero();
    test_gaps();
    test_wrap();
    test_result_hold();
    test_reset_midjob();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
